// File: rtl/jt900h_prefetch.sv
// rtl/jt900h_prefetch.sv - byte-oriented instruction prefetch queue fed by 16-bit bus reads
module jt900h_prefetch #(
    parameter int QD = 8,
    parameter int AW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          pc_load,
    input  logic [AW-1:0] pc_in,
    input  logic          adv,
    output logic [7:0]    md,
    output logic          md_ok,
    output logic [AW-1:0] pc,
    output logic          bus_rd,
    output logic [AW-1:0] bus_addr,
    input  logic [15:0]   bus_din,
    input  logic          bus_ack
);

    localparam int PW = $clog2(QD);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] QD_C = CW'(QD);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] fa;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_ptr1;
    logic [CW-1:0] cnt;
    logic          run;
    logic [7:0]    ram [0:QD-1];

    logic          consume;
    logic          wr_en;
    logic          issue;
    logic [CW-1:0] need;
    logic [CW-1:0] nbytes;
    logic [CW-1:0] cnt_after;
    logic [CW-1:0] free;

    // Queue bookkeeping and the request gate: a word is only requested when
    // the bytes it delivers are sure to fit, so cnt can never pass QD.
    always_comb begin
        consume   = adv & md_ok & ~pc_load;
        wr_en     = (state == REQ) & bus_ack & ~pc_load;
        need      = fa[0] ? CW'(1) : CW'(2);
        nbytes    = wr_en ? need : '0;
        cnt_after = cnt - CW'(consume);
        free      = QD_C - cnt_after;
        issue     = (state == IDLE) & run & ~pc_load & (free >= need);
        wr_ptr1   = wr_ptr + 1'b1;
        md_ok     = (cnt != '0);
        md        = md_ok ? ram[rd_ptr] : 8'd0;
    end

    // Fetch FSM next state; an ack always closes the bus cycle, a redirect
    // without ack leaves the read outstanding so its reply can be discarded.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (issue) state_nx = REQ;
            REQ: begin
                if (bus_ack)      state_nx = IDLE;
                else if (pc_load) state_nx = DROP;
            end
            DROP: if (bus_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Control state, pointers and addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fa       <= '0;
            pc       <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            run      <= 1'b0;
            bus_rd   <= 1'b0;
            bus_addr <= '0;
        end else if (cen) begin
            state  <= state_nx;
            bus_rd <= (state_nx != IDLE);
            if (issue) bus_addr <= {fa[AW-1:1], 1'b0};
            if (pc_load) begin
                run    <= 1'b1;
                fa     <= pc_in;
                pc     <= pc_in;
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (wr_en) begin
                    fa     <= fa + AW'(need);
                    wr_ptr <= wr_ptr + PW'(nbytes);
                end
                if (consume) begin
                    pc     <= pc + 1'b1;
                    rd_ptr <= rd_ptr + 1'b1;
                end
                cnt <= cnt_after + nbytes;
            end
        end
    end

    // Byte storage; an odd fetch address keeps only the upper byte of the word.
    always_ff @(posedge clk) begin
        if (cen && wr_en) begin
            if (fa[0]) begin
                ram[wr_ptr] <= bus_din[15:8];
            end else begin
                ram[wr_ptr]  <= bus_din[7:0];
                ram[wr_ptr1] <= bus_din[15:8];
            end
        end
    end

endmodule

// File: tb/tb_jt900h_prefetch.sv
// tb/tb_jt900h_prefetch.sv - directed, table-driven bench for jt900h_prefetch
module tb_jt900h_prefetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b1;
    logic        pc_load = 1'b0;
    logic [23:0] pc_in = '0;
    logic        adv = 1'b0;
    logic [7:0]  md;
    logic        md_ok;
    logic [23:0] pc;
    logic        bus_rd;
    logic [23:0] bus_addr;
    logic [15:0] bus_din = '0;
    logic        bus_ack = 1'b0;

    int checks = 0;
    int failures = 0;

    jt900h_prefetch #(.QD(8), .AW(24)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .pc_load  (pc_load),
        .pc_in    (pc_in),
        .adv      (adv),
        .md       (md),
        .md_ok    (md_ok),
        .pc       (pc),
        .bus_rd   (bus_rd),
        .bus_addr (bus_addr),
        .bus_din  (bus_din),
        .bus_ack  (bus_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cen;
        logic        pl;
        logic [23:0] pi;
        logic        adv;
        logic [15:0] din;
        logic        ack;
        logic        md_ok;
        logic [7:0]  md;
        logic [23:0] pc;
        logic        bus_rd;
        logic [23:0] addr;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic cyc(input logic pl, input logic [23:0] pi, input logic a,
                       input logic [15:0] d, input logic k);
        cen     = 1'b1;
        pc_load = pl;
        pc_in   = pi;
        adv     = a;
        bus_din = d;
        bus_ack = k;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 24'h0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic do_reset();
        cen = 1'b1; pc_load = 1'b0; adv = 1'b0; bus_ack = 1'b0; bus_din = '0; pc_in = '0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic outs(input string n, input logic eok, input logic [7:0] emd,
                        input logic [23:0] epc, input logic erd, input logic [23:0] ead);
        chk({n, ".md_ok"}, 32'(md_ok), 32'(eok));
        chk({n, ".md"}, 32'(md), 32'(emd));
        chk({n, ".pc"}, 32'(pc), 32'(epc));
        chk({n, ".bus_rd"}, 32'(bus_rd), 32'(erd));
        chk({n, ".bus_addr"}, 32'(bus_addr), 32'(ead));
    endtask

    initial begin
        // cen pl pi adv din ack | md_ok md pc bus_rd addr
        tbl[0]  = '{1'b1, 1'b1, 24'h000100, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 24'h000100, 1'b0, 24'h000000};
        tbl[1]  = '{1'b1, 1'b0, 24'h000000, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h00, 24'h000100, 1'b1, 24'h000100};
        tbl[2]  = '{1'b1, 1'b0, 24'h000000, 1'b1, 16'h3412, 1'b1, 1'b1, 8'h12, 24'h000100, 1'b0, 24'h000100};
        tbl[3]  = '{1'b1, 1'b0, 24'h000000, 1'b1, 16'h0000, 1'b0, 1'b1, 8'h34, 24'h000101, 1'b1, 24'h000102};
        tbl[4]  = '{1'b1, 1'b0, 24'h000000, 1'b1, 16'h7856, 1'b1, 1'b1, 8'h56, 24'h000102, 1'b0, 24'h000102};
        tbl[5]  = '{1'b1, 1'b0, 24'h000000, 1'b1, 16'h0000, 1'b0, 1'b1, 8'h78, 24'h000103, 1'b1, 24'h000104};
        tbl[6]  = '{1'b1, 1'b0, 24'h000000, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h00, 24'h000104, 1'b1, 24'h000104};
        tbl[7]  = '{1'b0, 1'b0, 24'h000000, 1'b1, 16'hBEEF, 1'b1, 1'b0, 8'h00, 24'h000104, 1'b1, 24'h000104};
        tbl[8]  = '{1'b1, 1'b0, 24'h000000, 1'b0, 16'hBEEF, 1'b1, 1'b1, 8'hEF, 24'h000104, 1'b0, 24'h000104};
        tbl[9]  = '{1'b1, 1'b0, 24'h000000, 1'b1, 16'h0000, 1'b0, 1'b1, 8'hBE, 24'h000105, 1'b1, 24'h000106};
        tbl[10] = '{1'b1, 1'b0, 24'h000000, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h00, 24'h000106, 1'b1, 24'h000106};

        // Reset state
        do_reset();
        outs("reset", 1'b0, 8'h00, 24'h0, 1'b0, 24'h0);

        // Sequential fetch with adv held, including a disabled-clock cycle
        for (int i = 0; i < 11; i++) begin
            cen     = tbl[i].cen;
            pc_load = tbl[i].pl;
            pc_in   = tbl[i].pi;
            adv     = tbl[i].adv;
            bus_din = tbl[i].din;
            bus_ack = tbl[i].ack;
            @(posedge clk);
            #1;
            outs($sformatf("v%0d", i), tbl[i].md_ok, tbl[i].md, tbl[i].pc, tbl[i].bus_rd, tbl[i].addr);
        end

        // Odd start address keeps only the upper byte
        do_reset();
        cyc(1'b1, 24'h000201, 1'b0, 16'h0, 1'b0);
        idle();
        outs("odd.req", 1'b0, 8'h00, 24'h000201, 1'b1, 24'h000200);
        cyc(1'b0, 24'h0, 1'b0, 16'hAB99, 1'b1);
        outs("odd.ack", 1'b1, 8'hAB, 24'h000201, 1'b0, 24'h000200);
        idle();
        outs("odd.next", 1'b1, 8'hAB, 24'h000201, 1'b1, 24'h000202);
        cyc(1'b0, 24'h0, 1'b1, 16'h0, 1'b0);
        chk("odd.drain", 32'(md_ok), 32'd0);
        cyc(1'b0, 24'h0, 1'b0, 16'h2211, 1'b1);
        outs("odd.w2", 1'b1, 8'h11, 24'h000202, 1'b0, 24'h000202);

        // Fill the queue: four words, then the gate holds until two bytes free
        do_reset();
        cyc(1'b1, 24'h000500, 1'b0, 16'h0, 1'b0);
        for (int w = 0; w < 4; w++) begin
            int n;
            n = 0;
            while (!bus_rd && n < 10) begin
                idle();
                n++;
            end
            chk($sformatf("fill.rd%0d", w), 32'(bus_rd), 32'd1);
            chk($sformatf("fill.addr%0d", w), 32'(bus_addr), 32'h500 + 32'(2 * w));
            cyc(1'b0, 24'h0, 1'b0, {8'hA1 + 8'(2 * w), 8'hA0 + 8'(2 * w)}, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            chk($sformatf("fill.full%0d", i), 32'(bus_rd), 32'd0);
        end
        chk("fill.md", 32'(md), 32'hA0);
        cyc(1'b0, 24'h0, 1'b1, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk($sformatf("fill.one%0d", i), 32'(bus_rd), 32'd0);
        end
        chk("fill.md1", 32'(md), 32'hA1);
        cyc(1'b0, 24'h0, 1'b1, 16'h0, 1'b0);
        outs("fill.two", 1'b1, 8'hA2, 24'h000502, 1'b1, 24'h000508);

        // Redirect while a request waits for ack: reply is dropped
        do_reset();
        cyc(1'b1, 24'h000300, 1'b0, 16'h0, 1'b0);
        idle();
        outs("drop.req", 1'b0, 8'h00, 24'h000300, 1'b1, 24'h000300);
        cyc(1'b1, 24'h000400, 1'b0, 16'h0, 1'b0);
        outs("drop.load", 1'b0, 8'h00, 24'h000400, 1'b1, 24'h000300);
        idle();
        idle();
        chk("drop.hold", 32'(bus_rd), 32'd1);
        cyc(1'b0, 24'h0, 1'b0, 16'hFFFF, 1'b1);
        outs("drop.ack", 1'b0, 8'h00, 24'h000400, 1'b0, 24'h000300);
        idle();
        outs("drop.next", 1'b0, 8'h00, 24'h000400, 1'b1, 24'h000400);
        cyc(1'b0, 24'h0, 1'b0, 16'h2211, 1'b1);
        outs("drop.data", 1'b1, 8'h11, 24'h000400, 1'b0, 24'h000400);

        // Redirect coinciding with adv and with an ack
        do_reset();
        cyc(1'b1, 24'h000600, 1'b0, 16'h0, 1'b0);
        idle();
        cyc(1'b0, 24'h0, 1'b0, 16'h3322, 1'b1);
        chk("coin.md", 32'(md), 32'h22);
        idle();
        chk("coin.req", 32'(bus_addr), 32'h602);
        cyc(1'b1, 24'h000700, 1'b1, 16'h5544, 1'b1);
        outs("coin.load", 1'b0, 8'h00, 24'h000700, 1'b0, 24'h000602);
        idle();
        outs("coin.next", 1'b0, 8'h00, 24'h000700, 1'b1, 24'h000700);
        cyc(1'b0, 24'h0, 1'b0, 16'h6677, 1'b1);
        outs("coin.data", 1'b1, 8'h77, 24'h000700, 1'b0, 24'h000700);

        // Address wrap at the top of the space
        do_reset();
        cyc(1'b1, 24'hFFFFFE, 1'b0, 16'h0, 1'b0);
        idle();
        outs("wrap.req", 1'b0, 8'h00, 24'hFFFFFE, 1'b1, 24'hFFFFFE);
        cyc(1'b0, 24'h0, 1'b0, 16'h2211, 1'b1);
        cyc(1'b0, 24'h0, 1'b1, 16'h0, 1'b0);
        outs("wrap.req2", 1'b1, 8'h22, 24'hFFFFFF, 1'b1, 24'h000000);
        cyc(1'b0, 24'h0, 1'b1, 16'h4433, 1'b1);
        outs("wrap.pc", 1'b1, 8'h33, 24'h000000, 1'b0, 24'h000000);

        // Asynchronous reset in the middle of a request; late reply ignored
        do_reset();
        cyc(1'b1, 24'h000800, 1'b0, 16'h0, 1'b0);
        idle();
        chk("areset.pre", 32'(bus_rd), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.rd", 32'(bus_rd), 32'd0);
        chk("areset.addr", 32'(bus_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 24'h0, 1'b0, 16'h1234, 1'b1);
        outs("areset.late", 1'b0, 8'h00, 24'h0, 1'b0, 24'h0);
        idle();
        chk("areset.quiet", 32'(bus_rd), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
